// File: rtl/y_alu_pkg.sv
// Shared encodings for the multi-cycle ALU: op codes, FSM states and the
// signed-overflow helper used by ADD/SUB.
package y_alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SLL = 3'b011,
    OP_SRL = 3'b100,
    OP_MUL = 3'b101,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Signed overflow: operand signs agree and the result sign differs.
  // For subtraction pass the sign of ~b as sb_eff.
  function automatic logic add_sub_ovf(input logic sa, input logic sb_eff, input logic sr);
    return (sa == sb_eff) && (sr != sa);
  endfunction

endpackage

// File: rtl/y_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle.
// start_i loads the operands; done_o is high in the cycle whose p_o already
// includes the last partial product, so the caller can register it directly.
module y_mul_iter
  import y_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] p_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] acc_next_s;
  logic             step_s;

  // Accumulator next value and next-state for the iteration registers.
  always_comb begin
    step_s     = busy_q && (cnt_q != {CW{1'b0}});
    acc_next_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    if (start_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = {WIDTH{1'b0}};
      cnt_d    = CW'(WIDTH);
      busy_d   = 1'b1;
    end else if (step_s) begin
      acc_d    = acc_next_s;
      mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      cnt_d    = cnt_q - CW'(1);
      busy_d   = (cnt_q != CW'(1));
    end else begin
      busy_d   = 1'b0;
    end
  end

  // Iteration state registers; reset clears counter and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign done_o = busy_q && (cnt_q == CW'(1));
  assign p_o    = acc_next_s;

endmodule

// File: rtl/y_alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes. Single-cycle ops are computed
// combinationally and registered at transfer; MUL runs in y_mul_iter.
module y_alu_mc
  import y_alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] res_s;
  logic             res_ovf_s;
  logic             res_err_s;
  logic             is_mul_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [SHW-1:0]   shamt_s;
  logic             transfer_s;
  logic             mul_start_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_p_s;

  assign transfer_s = in_valid && (state_q == ST_IDLE);

  // Single-cycle datapath; MUL is only flagged here, illegal ops give z=0/err.
  always_comb begin
    res_s     = {WIDTH{1'b0}};
    res_ovf_s = 1'b0;
    res_err_s = 1'b0;
    is_mul_s  = 1'b0;
    shamt_s   = b[SHW-1:0];
    sum_s     = a + b;
    diff_s    = a - b;
    case (op)
      OP_AND: res_s = a & b;
      OP_OR:  res_s = a | b;
      OP_ADD: begin
        res_s     = sum_s;
        res_ovf_s = add_sub_ovf(a[WIDTH-1], b[WIDTH-1], sum_s[WIDTH-1]);
      end
      OP_SUB: begin
        res_s     = diff_s;
        res_ovf_s = add_sub_ovf(a[WIDTH-1], ~b[WIDTH-1], diff_s[WIDTH-1]);
      end
      OP_SLT: res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: res_s = a << shamt_s;
      OP_SRL: res_s = a >> shamt_s;
      OP_MUL: begin
        if (MUL_EN != 0) begin
          is_mul_s = 1'b1;
        end else begin
          res_err_s = 1'b1;
        end
      end
      default: res_err_s = 1'b1;
    endcase
  end

  // FSM next state and result registers; zero always tracks the value loaded into z.
  always_comb begin
    state_d     = state_q;
    z_d         = z_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    mul_start_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (transfer_s) begin
          if (is_mul_s) begin
            state_d     = ST_BUSY;
            mul_start_s = 1'b1;
          end else begin
            state_d     = ST_DONE;
            z_d         = res_s;
            zero_d      = (res_s == {WIDTH{1'b0}});
            ovf_d       = res_ovf_s;
            err_d       = res_err_s;
            out_valid_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mul_done_s) begin
          state_d     = ST_DONE;
          z_d         = mul_p_s;
          zero_d      = (mul_p_s == {WIDTH{1'b0}});
          ovf_d       = 1'b0;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      z_q         <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      z_q         <= z_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  y_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mul_start_s),
    .a_i     (a),
    .b_i     (b),
    .done_o  (mul_done_s),
    .p_o     (mul_p_s)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_y_alu_mc.sv
// Bench for y_alu_mc: three instances (32-bit, 8-bit, 32-bit without MUL)
// share stimulus; one is selected at a time. Expected results go through a
// scoreboard queue and are compared when out_valid appears.
module tb_y_alu_mc;
  import y_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a, b;
  logic [2:0]  op;
  int          sel;

  logic [2:0]  rdy, ov, zr, of, er;
  logic [31:0] z0, z2;
  logic [7:0]  z1;

  logic        rdy_m, ov_m, zr_m, of_m, er_m;
  logic [31:0] z_m;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] z;
    logic        zero;
    logic        ovf;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    int          sel;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    logic        zero;
    logic        ovf;
    logic        err;
  } vec_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  y_alu_mc #(.WIDTH(32), .MUL_EN(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(rdy[0]),
    .a(a), .b(b), .op(op), .out_valid(ov[0]), .out_ready(out_ready),
    .z(z0), .zero(zr[0]), .ovf(of[0]), .err(er[0]));

  y_alu_mc #(.WIDTH(8), .MUL_EN(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(rdy[1]),
    .a(a[7:0]), .b(b[7:0]), .op(op), .out_valid(ov[1]), .out_ready(out_ready),
    .z(z1), .zero(zr[1]), .ovf(of[1]), .err(er[1]));

  y_alu_mc #(.WIDTH(32), .MUL_EN(0)) dutnm (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2), .in_ready(rdy[2]),
    .a(a), .b(b), .op(op), .out_valid(ov[2]), .out_ready(out_ready),
    .z(z2), .zero(zr[2]), .ovf(of[2]), .err(er[2]));

  // Route the selected instance's outputs to the checker.
  always_comb begin
    case (sel)
      1:       z_m = {24'h0, z1};
      2:       z_m = z2;
      default: z_m = z0;
    endcase
    rdy_m = rdy[sel];
    ov_m  = ov[sel];
    zr_m  = zr[sel];
    of_m  = of[sel];
    er_m  = er[sel];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t sel=%0d)", nm, act, exp, $time, sel);
    end
  endtask

  function automatic int width_of(input int s);
    return (s == 1) ? 8 : 32;
  endfunction

  // Reference model using true signed arithmetic on wide integers.
  function automatic exp_t model(input int s, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    exp_t        e;
    int          w;
    logic [31:0] m, am, bm, r;
    longint      sa, sb, t, maxv, minv;
    logic [63:0] p;
    int          sh;
    w    = width_of(s);
    m    = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    am   = av & m;
    bm   = bv & m;
    sa   = am[w-1] ? longint'(am) - (longint'(1) << w) : longint'(am);
    sb   = bm[w-1] ? longint'(bm) - (longint'(1) << w) : longint'(bm);
    maxv = (longint'(1) << (w - 1)) - 1;
    minv = -(longint'(1) << (w - 1));
    sh   = int'(bm & 32'(w - 1));
    e.ovf = 1'b0;
    e.err = 1'b0;
    e.lat = 1;
    r     = 32'h0;
    case (o)
      3'b000: r = am & bm;
      3'b001: r = am | bm;
      3'b010: begin r = (am + bm) & m; t = sa + sb; e.ovf = (t > maxv) || (t < minv); end
      3'b110: begin r = (am - bm) & m; t = sa - sb; e.ovf = (t > maxv) || (t < minv); end
      3'b111: r = (sa < sb) ? 32'h1 : 32'h0;
      3'b011: r = (am << sh) & m;
      3'b100: r = am >> sh;
      default: begin
        if (s != 2) begin
          p     = {32'h0, am} * {32'h0, bm};
          r     = p[31:0] & m;
          e.lat = w + 1;
        end else begin
          e.err = 1'b1;
        end
      end
    endcase
    e.z    = r;
    e.zero = (r == 32'h0);
    return e;
  endfunction

  // One transaction: push expectation, transfer, wait for result, hold, accept.
  task automatic run_op(input int s, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input exp_t e, input int hold);
    exp_t got;
    int   lat;
    bit   seen_rdy;
    bit   unstable;
    sb_q.push_back(e);
    @(negedge clk);
    sel = s; op = o; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("idle_ready", rdy_m, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom);
    lat = 1; seen_rdy = 0;
    while (ov_m !== 1'b1 && lat < 80) begin
      if (rdy_m) seen_rdy = 1;
      @(posedge clk); #1;
      lat++;
      a = $urandom; b = $urandom;
      out_ready = (lat < 4);
    end
    out_ready = 1'b0;
    got = sb_q.pop_front();
    chk("latency", lat, got.lat);
    if (got.lat > 1) chk("busy_ready_low", {31'h0, seen_rdy}, 0);
    chk("z", z_m, got.z);
    chk("zero", zr_m, got.zero);
    chk("ovf", of_m, got.ovf);
    chk("err", er_m, got.err);
    unstable = 0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (ov_m !== 1'b1 || z_m !== got.z || zr_m !== got.zero ||
          of_m !== got.ovf || er_m !== got.err) unstable = 1;
      a = $urandom; b = $urandom; op = 3'($urandom); in_valid = 1'($urandom);
    end
    in_valid = 1'b0;
    if (hold > 0) chk("hold_stable", {31'h0, unstable}, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", ov_m, 0);
    chk("ready_after_accept", rdy_m, 1);
  endtask

  // Start an op, apply reset after 'at' further edges, check clear and no ghost result.
  task automatic reset_during(input int s, input logic [2:0] o, input int at);
    bit ghost;
    @(negedge clk);
    sel = s; op = o; a = 32'hFFFF_FFFD; b = 32'h0000_0007; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (at == 0) chk("pre_reset_valid", ov_m, 1);
    repeat (at) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", ov_m, 0);
    chk("rst_z", z_m, 0);
    chk("rst_zero", zr_m, 0);
    chk("rst_ovf", of_m, 0);
    chk("rst_err", er_m, 0);
    chk("rst_ready", rdy_m, 1);
    @(negedge clk);
    rst_n = 1'b1;
    ghost = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (ov_m !== 1'b0) ghost = 1;
    end
    chk("no_ghost_result", {31'h0, ghost}, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    exp_t e;
    int   s;
    logic [2:0]  o;
    logic [31:0] av, bv;

    vt = '{
      '{0, 3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0},
      '{0, 3'b110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b0},
      '{0, 3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0},
      '{0, 3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0},
      '{0, 3'b011, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1'b0, 1'b0},
      '{0, 3'b100, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0, 1'b0},
      '{0, 3'b101, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0},
      '{0, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0},
      '{0, 3'b001, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1'b0, 1'b0},
      '{0, 3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0},
      '{0, 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0},
      '{2, 3'b101, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b1, 1'b0, 1'b1},
      '{1, 3'b010, 32'h0000_007F, 32'h0000_0001, 32'h0000_0080, 1'b0, 1'b1, 1'b0},
      '{1, 3'b101, 32'h0000_00FD, 32'h0000_0007, 32'h0000_00EB, 1'b0, 1'b0, 1'b0},
      '{1, 3'b011, 32'h0000_0001, 32'h0000_000B, 32'h0000_0008, 1'b0, 1'b0, 1'b0}
    };

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 32'h0; b = 32'h0; op = 3'b000; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", ov_m, 0);
    chk("reset_z", z_m, 0);
    chk("reset_zero", zr_m, 0);
    chk("reset_ovf", of_m, 0);
    chk("reset_err", er_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", rdy_m, 1);

    foreach (vt[i]) begin
      e.z    = vt[i].z;
      e.zero = vt[i].zero;
      e.ovf  = vt[i].ovf;
      e.err  = vt[i].err;
      e.lat  = (vt[i].op == 3'b101 && vt[i].sel != 2) ? width_of(vt[i].sel) + 1 : 1;
      run_op(vt[i].sel, vt[i].op, vt[i].a, vt[i].b, e, (i % 4 == 2) ? 10 : 1);
    end

    reset_during(0, 3'b101, 10);
    reset_during(0, 3'b010, 0);
    reset_during(1, 3'b101, 3);

    for (int r = 0; r < 420; r++) begin
      s  = (r < 200) ? 1 : ((r < 400) ? 0 : 2);
      o  = 3'($urandom);
      av = $urandom;
      bv = $urandom;
      if (r % 7 == 0) bv = av;
      e  = model(s, o, av, bv);
      run_op(s, o, av, bv, e, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
